// File: rtl/sram_arb_controller_pkg.sv
// Shared types for the multi-channel SRAM controller: FSM state encoding and
// the width of the programmable wait-state counter.
package sram_ctrl_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        TURN   = 2'd3
    } state_t;

endpackage

// File: rtl/sram_arb_controller_if.sv
// Requester-side bus of the SRAM controller: packed per-channel commands in,
// one-hot grant/ack pulses and shared read data out.
interface sram_arb_controller_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_CH-1:0]              req_i;
    logic [NUM_CH-1:0]              wr_en_i;
    logic [NUM_CH*ADDR_WIDTH-1:0]   addr_i;
    logic [NUM_CH*DATA_WIDTH-1:0]   wdata_i;
    logic [NUM_CH*DATA_WIDTH/8-1:0] be_i;
    logic [NUM_CH-1:0]              gnt_o;
    logic [NUM_CH-1:0]              ack_o;
    logic [DATA_WIDTH-1:0]          rdata_o;

    // Handshake: a requester holds req_i and its command stable until it sees
    // its gnt_o pulse; the matching ack_o pulse marks completion, and for reads
    // rdata_o is valid in that cycle and held until the next read completes.
    modport master (
        output req_i, wr_en_i, addr_i, wdata_i, be_i,
        input  gnt_o, ack_o, rdata_o
    );

    modport slave (
        input  req_i, wr_en_i, addr_i, wdata_i, be_i,
        output gnt_o, ack_o, rdata_o
    );

endinterface

// File: rtl/sram_arb_controller_rr_arbiter.sv
// Round-robin arbiter: the pointer channel has highest priority and the
// pointer moves just past the winner each time a grant is taken.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [IW-1:0] index
);
    logic [IW-1:0] ptr;

    // Scan from lowest priority to highest so the last hit (closest to ptr) wins.
    always_comb begin : pick
        int c;
        grant = '0;
        index = '0;
        c     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c[IW-1:0]]) begin
                grant             = '0;
                grant[c[IW-1:0]]  = 1'b1;
                index             = c[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (index == IW'(N - 1)) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/sram_arb_controller.sv
// Multi-channel SRAM controller: round-robin arbitration, latched command,
// SETUP/ACCESS/TURN sequencing with programmable wait states and bus turnaround.
module sram_arb_controller
    import sram_ctrl_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  ADDR_WIDTH = 8,
    parameter int  DATA_WIDTH = 16,
    parameter int  RD_WAIT    = 1,
    parameter int  WR_WAIT    = 1,
    localparam int BE_W       = DATA_WIDTH / 8,
    localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  sram_clk,
    input  logic                  rst,
    sram_arb_controller_if.slave  bus,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    inout  wire  [DATA_WIDTH-1:0] sram_data_io,
    output logic [BE_W-1:0]       sram_be_o,
    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic                  sram_oe_o,
    output state_t                dbg_state,
    output logic                  dbg_bus_en
);
    localparam int MAX_WAIT = (1 << WAIT_CNT_W) - 1;

    if (RD_WAIT < 0 || RD_WAIT > MAX_WAIT || WR_WAIT < 0 || WR_WAIT > MAX_WAIT) begin : g_bad_wait
        $error("sram_arb_controller: RD_WAIT/WR_WAIT must be within 0..15");
    end
    if (DATA_WIDTH % 8 != 0 || NUM_CH < 1) begin : g_bad_width
        $error("sram_arb_controller: DATA_WIDTH must be a multiple of 8 and NUM_CH >= 1");
    end

    state_t                  state;
    logic [NUM_CH-1:0]       win_grant;
    logic [IDX_W-1:0]        win_idx;
    logic                    advance;
    logic                    active;
    logic                    cmd_wr;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [BE_W-1:0]         cmd_be;
    logic [IDX_W-1:0]        cmd_ch;
    logic [WAIT_CNT_W-1:0]   wait_cnt;

    assign advance = (state == IDLE) && (|bus.req_i);

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (sram_clk),
        .rst     (rst),
        .req     (bus.req_i),
        .advance (advance),
        .grant   (win_grant),
        .index   (win_idx)
    );

    always_ff @(posedge sram_clk) begin
        if (rst) begin
            state       <= IDLE;
            bus.gnt_o   <= '0;
            bus.ack_o   <= '0;
            bus.rdata_o <= '0;
            cmd_wr      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_be      <= '0;
            cmd_ch      <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.ack_o <= '0;
                    if (advance) begin
                        cmd_wr    <= bus.wr_en_i[win_idx];
                        cmd_addr  <= bus.addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        cmd_wdata <= bus.wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        cmd_be    <= bus.be_i[win_idx*BE_W +: BE_W];
                        cmd_ch    <= win_idx;
                        bus.gnt_o <= win_grant;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    bus.gnt_o <= '0;
                    wait_cnt  <= cmd_wr ? WAIT_CNT_W'(WR_WAIT) : WAIT_CNT_W'(RD_WAIT);
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // Last access cycle: the SRAM has had WAIT+1 cycles to settle.
                    if (wait_cnt == '0) begin
                        if (!cmd_wr) begin
                            bus.rdata_o <= sram_data_io;
                        end
                        bus.ack_o <= NUM_CH'(1) << cmd_ch;
                        state     <= TURN;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                TURN: begin
                    bus.ack_o <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        active      = (state == SETUP) || (state == ACCESS);
        sram_ce_o   = active;
        sram_we_o   = (state == ACCESS) && cmd_wr;
        sram_oe_o   = active && !cmd_wr;
        dbg_bus_en  = active && cmd_wr;
        sram_be_o   = active ? (cmd_wr ? cmd_be : '1) : '0;
        sram_addr_o = cmd_addr;
        dbg_state   = state;
    end

    // Pads are released during TURN so the SRAM can drive again without contention.
    assign sram_data_io = dbg_bus_en ? cmd_wdata : 'z;

endmodule

// File: tb/tb_sram_arb_controller.sv
// Bench for sram_arb_controller: SRAM pad model, round-robin/memory reference
// model, directed scenarios plus randomized request groups.
module tb_sram_arb_controller;
    import sram_ctrl_pkg::*;

    localparam int NCH  = 4;
    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int BW   = 2;
    localparam int WAIT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arb_controller_if #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wire  [DW-1:0] sram_data;
    logic [AW-1:0] sram_addr;
    logic [BW-1:0] sram_be;
    logic          sram_ce, sram_we, sram_oe;
    state_t        dbg_state;
    logic          dbg_bus_en;

    sram_arb_controller #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(WAIT), .WR_WAIT(WAIT)
    ) dut (
        .sram_clk     (clk),
        .rst          (rst),
        .bus          (bus),
        .sram_addr_o  (sram_addr),
        .sram_data_io (sram_data),
        .sram_be_o    (sram_be),
        .sram_ce_o    (sram_ce),
        .sram_we_o    (sram_we),
        .sram_oe_o    (sram_oe),
        .dbg_state    (dbg_state),
        .dbg_bus_en   (dbg_bus_en)
    );

    // Asynchronous SRAM pad model
    logic [DW-1:0] sram_mem [256] = '{default: '0};
    assign sram_data = (sram_ce && sram_oe && !sram_we) ? sram_mem[sram_addr] : 'z;
    always @(posedge clk) begin
        if (sram_ce && sram_we) begin
            for (int b = 0; b < BW; b++) begin
                if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_data[b*8 +: 8];
            end
        end
    end

    // Reference model and bookkeeping
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q [$];
    int            m_ptr;
    logic          c_wr   [NCH];
    logic [AW-1:0] c_addr [NCH];
    logic [DW-1:0] c_data [NCH];
    logic [BW-1:0] c_be   [NCH];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int g_start;
    int obs_ch [$];
    int obs_gcyc [$];
    int obs_acyc [$];
    logic [NCH-1:0] obs_ack [$];
    logic [DW-1:0]  obs_rd [$];
    int we_first, we_cnt, oe_first, oe_cnt;
    logic [DW-1:0] we_data;
    logic [BW-1:0] we_be;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] pend, input int ptr);
        for (int k = 0; k < NCH; k++) begin
            if (pend[(ptr + k) % NCH]) return (ptr + k) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic set_cmd(input int c, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        c_wr[c] = w; c_addr[c] = a; c_data[c] = d; c_be[c] = be;
        bus.wr_en_i[c]          = w;
        bus.addr_i[c*AW +: AW]  = a;
        bus.wdata_i[c*DW +: DW] = d;
        bus.be_i[c*BW +: BW]    = be;
    endtask

    // Raise req for every channel in mask, drop each on its grant, collect grants/acks.
    task automatic run_group(input logic [NCH-1:0] mask);
        logic [NCH-1:0] pend;
        int budget;
        pend = mask;
        obs_ch.delete(); obs_gcyc.delete(); obs_acyc.delete(); obs_ack.delete(); obs_rd.delete();
        we_first = -1; we_cnt = 0; oe_first = -1; oe_cnt = 0; we_data = '0; we_be = '0;
        g_start = cyc;
        bus.req_i = mask;
        budget = 0;
        while ((pend != '0 || obs_acyc.size() < obs_ch.size()) && budget < 200) begin
            tick();
            budget++;
            for (int c = 0; c < NCH; c++) begin
                if (bus.gnt_o[c]) begin
                    obs_ch.push_back(c);
                    obs_gcyc.push_back(cyc);
                    pend[c] = 1'b0;
                    bus.req_i[c] = 1'b0;
                end
            end
            if (bus.ack_o != '0) begin
                obs_acyc.push_back(cyc);
                obs_ack.push_back(bus.ack_o);
                obs_rd.push_back(bus.rdata_o);
            end
            if (sram_we) begin
                if (we_cnt == 0) we_first = cyc;
                we_cnt++;
                we_data = sram_data;
                we_be = sram_be;
            end
            if (sram_oe) begin
                if (oe_cnt == 0) oe_first = cyc;
                oe_cnt++;
            end
        end
        bus.req_i = '0;
        checks++;
        if (budget >= 200) begin
            errors++;
            $display("FAIL group_timeout: pending=%b grants=%0d acks=%0d, required all served",
                     pend, obs_ch.size(), obs_acyc.size());
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.gnt_o !== 4'b0) begin errors++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt_o); end
        checks++; if (bus.ack_o !== 4'b0) begin errors++; $display("FAIL rst_ack: got %b want 0000", bus.ack_o); end
        checks++; if (bus.rdata_o !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0000", bus.rdata_o); end
        checks++; if ({sram_ce, sram_we, sram_oe} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got ce/we/oe=%b want 000", {sram_ce, sram_we, sram_oe}); end
        checks++; if (sram_be !== 2'b00) begin errors++; $display("FAIL rst_be: got %b want 00", sram_be); end
        checks++; if (sram_addr !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h want 00", sram_addr); end
        checks++; if (dbg_bus_en !== 1'b0) begin errors++; $display("FAIL rst_bus_z: bus driven=%b want 0", dbg_bus_en); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
        rst = 1'b0;
        m_ptr = 0;
        tick();
    endtask

    task automatic test_write();
        set_cmd(0, 1'b1, 8'h12, 16'hBEEF, 2'b11);
        run_group(4'b0001);
        ref_mem[8'h12] = merge(ref_mem[8'h12], 16'hBEEF, 2'b11);
        m_ptr = 1;
        checks++; if (obs_ch.size() != 1 || obs_gcyc[0] != g_start + 1) begin errors++; $display("FAIL wr_gnt_time: grants=%0d at cycle %0d want 1 at %0d", obs_ch.size(), (obs_gcyc.size() > 0) ? obs_gcyc[0] : -1, g_start + 1); end
        checks++; if (we_first != g_start + 2 || we_cnt != 2) begin errors++; $display("FAIL wr_we_window: first=%0d cnt=%0d want first=%0d cnt=2", we_first, we_cnt, g_start + 2); end
        checks++; if (we_data !== 16'hBEEF) begin errors++; $display("FAIL wr_bus_data: got %h want BEEF", we_data); end
        checks++; if (obs_acyc.size() != 1 || obs_acyc[0] != g_start + 4 || obs_ack[0] !== 4'b0001) begin errors++; $display("FAIL wr_ack: count=%0d cycle=%0d want 1 pulse 0001 at %0d", obs_acyc.size(), (obs_acyc.size() > 0) ? obs_acyc[0] : -1, g_start + 4); end
    endtask

    task automatic test_read();
        set_cmd(0, 1'b0, 8'h12, 16'($urandom), 2'($urandom_range(0, 3)));
        run_group(4'b0001);
        m_ptr = 1;
        exp_q.push_back(ref_mem[8'h12]);
        checks++; if (oe_first != g_start + 1 || oe_cnt != 3) begin errors++; $display("FAIL rd_oe_window: first=%0d cnt=%0d want first=%0d cnt=3", oe_first, oe_cnt, g_start + 1); end
        checks++; if (obs_acyc.size() != 1 || obs_acyc[0] != g_start + 4) begin errors++; $display("FAIL rd_ack_time: count=%0d cycle=%0d want 1 at %0d", obs_acyc.size(), (obs_acyc.size() > 0) ? obs_acyc[0] : -1, g_start + 4); end
        checks++; if (obs_rd.size() != 1 || obs_rd[0] !== exp_q[0] || exp_q[0] !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h want %h", (obs_rd.size() > 0) ? obs_rd[0] : 16'hxxxx, exp_q[0]); end
        tick(); tick();
        checks++; if (bus.rdata_o !== exp_q[0]) begin errors++; $display("FAIL rd_hold: got %h want %h", bus.rdata_o, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_round_robin();
        int want;
        logic [NCH-1:0] pend;
        rst = 1'b1; tick(); rst = 1'b0; m_ptr = 0; tick();
        for (int c = 0; c < NCH; c++) set_cmd(c, 1'b1, 8'(8'h20 + c), 16'($urandom), 2'b11);
        run_group(4'b1111);
        pend = 4'b1111;
        for (int i = 0; i < NCH; i++) begin
            want = rr_pick(pend, m_ptr);
            pend[want] = 1'b0;
            m_ptr = (want + 1) % NCH;
            ref_mem[c_addr[want]] = merge(ref_mem[c_addr[want]], c_data[want], c_be[want]);
            checks++; if (i >= obs_ch.size() || obs_ch[i] != want) begin errors++; $display("FAIL rr_all_order[%0d]: got ch%0d want ch%0d", i, (i < obs_ch.size()) ? obs_ch[i] : -1, want); end
            if (i > 0 && i < obs_gcyc.size()) begin
                checks++; if (obs_gcyc[i] - obs_gcyc[i-1] != 4 + WAIT) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles want %0d", i, obs_gcyc[i] - obs_gcyc[i-1], 4 + WAIT); end
            end
        end
        run_group(4'b0101);
        pend = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            want = rr_pick(pend, m_ptr);
            pend[want] = 1'b0;
            m_ptr = (want + 1) % NCH;
            ref_mem[c_addr[want]] = merge(ref_mem[c_addr[want]], c_data[want], c_be[want]);
            checks++; if (i >= obs_ch.size() || obs_ch[i] != want || i >= obs_ack.size() || obs_ack[i] !== NCH'(1 << want)) begin errors++; $display("FAIL rr_pair_order[%0d]: got ch%0d want ch%0d", i, (i < obs_ch.size()) ? obs_ch[i] : -1, want); end
        end
    endtask

    task automatic test_byte_enable();
        set_cmd(3, 1'b1, 8'h40, 16'hFFFF, 2'b11);
        run_group(4'b1000);
        set_cmd(3, 1'b1, 8'h40, 16'h00AA, 2'b01);
        run_group(4'b1000);
        checks++; if (we_be !== 2'b01) begin errors++; $display("FAIL be_access: got %b want 01", we_be); end
        set_cmd(3, 1'b0, 8'h40, 16'h0000, 2'b00);
        run_group(4'b1000);
        m_ptr = 0;
        ref_mem[8'h40] = merge(merge(ref_mem[8'h40], 16'hFFFF, 2'b11), 16'h00AA, 2'b01);
        checks++; if (obs_rd.size() != 1 || obs_rd[0] !== ref_mem[8'h40] || ref_mem[8'h40] !== 16'hFFAA) begin errors++; $display("FAIL be_readback: got %h want FFAA", (obs_rd.size() > 0) ? obs_rd[0] : 16'hxxxx); end
        checks++; if (sram_be !== 2'b00) begin errors++; $display("FAIL be_idle: got %b want 00", sram_be); end
    endtask

    task automatic test_reset_mid();
        int n;
        int acks;
        set_cmd(1, 1'b1, 8'hF0, 16'h1234, 2'b11);
        bus.req_i = 4'b0010;
        n = 0;
        while (bus.gnt_o == '0 && n < 20) begin tick(); n++; end
        bus.req_i = '0;
        checks++; if (bus.gnt_o !== 4'b0010) begin errors++; $display("FAIL mid_gnt: got %b want 0010", bus.gnt_o); end
        tick();
        checks++; if (dbg_state !== ACCESS || sram_we !== 1'b1) begin errors++; $display("FAIL mid_access: state=%0d we=%b want ACCESS/1", dbg_state, sram_we); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        checks++; if ({sram_ce, sram_we, dbg_bus_en} !== 3'b000) begin errors++; $display("FAIL mid_rst_ctrl: ce/we/drive=%b want 000", {sram_ce, sram_we, dbg_bus_en}); end
        checks++; if (dbg_state !== IDLE || bus.ack_o !== 4'b0) begin errors++; $display("FAIL mid_rst_state: state=%0d ack=%b want IDLE/0000", dbg_state, bus.ack_o); end
        acks = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.ack_o != '0) acks++; end
        checks++; if (acks != 0) begin errors++; $display("FAIL mid_no_ack: got %0d ack pulses want 0", acks); end
        set_cmd(0, 1'b0, 8'h12, 16'h0, 2'b00);
        set_cmd(1, 1'b0, 8'h40, 16'h0, 2'b00);
        run_group(4'b0011);
        checks++; if (obs_ch.size() != 2 || obs_ch[0] != rr_pick(4'b0011, m_ptr) || obs_ch[0] != 0) begin errors++; $display("FAIL mid_rearb: first ch%0d want ch0", (obs_ch.size() > 0) ? obs_ch[0] : -1); end
        checks++; if (obs_rd.size() != 2 || obs_rd[0] !== ref_mem[8'h12] || obs_rd[1] !== ref_mem[8'h40]) begin errors++; $display("FAIL mid_rd: got %h/%h want %h/%h", (obs_rd.size() > 0) ? obs_rd[0] : 16'hxxxx, (obs_rd.size() > 1) ? obs_rd[1] : 16'hxxxx, ref_mem[8'h12], ref_mem[8'h40]); end
        m_ptr = 2;
    endtask

    task automatic test_random();
        logic [NCH-1:0] mask, pend;
        int want;
        for (int it = 0; it < 25; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++)
                set_cmd(c, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(1, 3)));
            run_group(mask);
            pend = mask;
            for (int i = 0; i < $countones(mask); i++) begin
                want = rr_pick(pend, m_ptr);
                pend[want] = 1'b0;
                m_ptr = (want + 1) % NCH;
                checks++;
                if (i >= obs_ch.size() || obs_ch[i] != want || i >= obs_ack.size() || obs_ack[i] !== NCH'(1 << want) || obs_acyc[i] - obs_gcyc[i] != 3) begin
                    errors++;
                    $display("FAIL rand_txn[%0d.%0d]: ch%0d want ch%0d", it, i, (i < obs_ch.size()) ? obs_ch[i] : -1, want);
                end else if (c_wr[want]) begin
                    ref_mem[c_addr[want]] = merge(ref_mem[c_addr[want]], c_data[want], c_be[want]);
                end else begin
                    exp_q.push_back(ref_mem[c_addr[want]]);
                    checks++;
                    if (obs_rd[i] !== exp_q[0]) begin errors++; $display("FAIL rand_rd[%0d.%0d]: got %h want %h", it, i, obs_rd[i], exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        bus.req_i = '0; bus.wr_en_i = '0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = '0;
        m_ptr = 0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_byte_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
